transmit: RTL and testbench

Serial transmitter for the single-wire link; the counterpart of the link's receive block. Accepts parallel bytes through a valid/ready handshake, buffers one byte, and shifts frames out on `txd`. Each frame is one start bit (0), 8 data bits MSB first, and one stop bit (1). Sits between the system core and the outgoing line; default timing is one bit per clock, matching the receiver's sampling.

---
 rtl/link_pkg.sv | 18 +
 rtl/bit_timer.sv | 29 ++
 rtl/transmit.sv | 125 ++++++++++++
 tb/tb_transmit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants and types for the single-wire serial link.
// Used by both the transmit and receive ends.
package link_pkg;

    localparam int DATA_BITS = 8;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter for the serial link.
// Raises tick on the last clock of every bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/transmit.sv
// Serial frame transmitter: start bit, 8 data bits MSB first, stop bit.
// One byte of buffering lets frames run back to back without a gap.
module transmit
    import link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic       send,
    output logic       ready,
    output logic       txd,
    output logic       done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_t state, state_n;

    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] buf_data, buf_data_n;
    logic                 buf_full, buf_full_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic                 txd_q, txd_n;
    logic                 tick;
    logic                 accept;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(state == IDLE),
        .tick   (tick)
    );

    assign ready  = !buf_full;
    assign accept = send && ready;
    assign txd    = txd_q;
    assign done   = (state == STOP) && tick;

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        buf_data_n = buf_data;
        buf_full_n = buf_full;
        bit_cnt_n  = bit_cnt;

        // A byte goes to the buffer unless the shifter is free right now.
        if (accept && !(state == IDLE || (state == STOP && tick))) begin
            buf_full_n = 1'b1;
            buf_data_n = word;
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    shift_n = word;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n   = STOP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                        shift_n   = {shift[DATA_BITS-2:0], 1'b0};
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (buf_full) begin
                        state_n    = START;
                        shift_n    = buf_data;
                        buf_full_n = 1'b0;
                    end else if (accept) begin
                        state_n = START;
                        shift_n = word;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        unique case (state_n)
            START:   txd_n = START_LEVEL;
            DATA:    txd_n = shift_n[DATA_BITS-1];
            STOP:    txd_n = STOP_LEVEL;
            default: txd_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            bit_cnt  <= '0;
            txd_q    <= IDLE_LEVEL;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            buf_data <= buf_data_n;
            buf_full <= buf_full_n;
            bit_cnt  <= bit_cnt_n;
            txd_q    <= txd_n;
        end
    end

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit at one and four clocks per bit.
// Per-cycle vector tables plus hand-written reset and slow-rate runs.
module tb_transmit;

    typedef struct packed {
        logic       rst;
        logic       send;
        logic [7:0] word;
        logic       txd;
        logic       ready;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst1, send1, ready1, txd1, done1;
    logic [7:0] word1;
    logic       rst4, send4, ready4, txd4, done4;
    logic [7:0] word4;

    int total = 0;
    int bad   = 0;

    vec_t tv[$];

    always #5 clk = ~clk;

    transmit #(.CLKS_PER_BIT(1)) dut1 (
        .clk  (clk),
        .rst  (rst1),
        .word (word1),
        .send (send1),
        .ready(ready1),
        .txd  (txd1),
        .done (done1)
    );

    transmit #(.CLKS_PER_BIT(4)) dut4 (
        .clk  (clk),
        .rst  (rst4),
        .word (word4),
        .send (send4),
        .ready(ready4),
        .txd  (txd4),
        .done (done4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: {txd,ready,done} got %b want %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [7:0] w,
                                input logic t, input logic r,
                                input logic d);
        vec_t v;
        v.rst   = 1'b1;
        v.send  = s;
        v.word  = w;
        v.txd   = t;
        v.ready = r;
        v.done  = d;
        return v;
    endfunction

    task automatic run_table(input string name);
        foreach (tv[i]) begin
            rst1  = tv[i].rst;
            send1 = tv[i].send;
            word1 = tv[i].word;
            step();
            chk($sformatf("%s[%0d]", name, i), {txd1, ready1, done1},
                {tv[i].txd, tv[i].ready, tv[i].done});
        end
        send1 = 1'b0;
    endtask

    initial begin
        logic fb [10];
        fb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst1 = 1'b0; send1 = 1'b1; word1 = 8'h55;
        rst4 = 1'b0; send4 = 1'b0; word4 = 8'h00;

        // reset held with send high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", {txd1, ready1, done1}, 3'b110);
        end
        rst1 = 1'b1; rst4 = 1'b1; send1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", {txd1, ready1, done1}, 3'b110);
        end

        // single byte A5
        tv.delete();
        tv.push_back(mk(1, 8'hA5, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 1));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        run_table("a5");

        // 0F then buffered F0, FF ignored while full
        tv.delete();
        tv.push_back(mk(1, 8'h0F, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(1, 8'hF0, 0, 0, 0));
        tv.push_back(mk(1, 8'hFF, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, 0));
        tv.push_back(mk(1, 8'hFF, 1, 0, 1));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 1));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        tv.push_back(mk(0, 8'h00, 1, 1, 0));
        run_table("b2b");

        // four clocks per bit, byte 81
        send4 = 1'b1; word4 = 8'h81;
        step();
        send4 = 1'b0; word4 = 8'h00;
        for (int k = 1; k <= 44; k++) begin
            chk($sformatf("slow[%0d]", k), {txd4, ready4, done4},
                {(k <= 40) ? fb[(k - 1) / 4] : 1'b1, 1'b1, k == 40});
            step();
        end

        // reset during data bit 3 of 00 with FF buffered
        send1 = 1'b1; word1 = 8'h00;
        step();
        send1 = 1'b0;
        step();
        send1 = 1'b1; word1 = 8'hFF;
        step();
        send1 = 1'b0;
        chk("midrst_buffered", {txd1, ready1, done1}, 3'b000);
        step();
        step();
        chk("midrst_bit3", {txd1, ready1, done1}, 3'b000);
        rst1 = 1'b0;
        step();
        chk("midrst_abort", {txd1, ready1, done1}, 3'b110);
        rst1 = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            chk($sformatf("midrst_quiet[%0d]", i), {txd1, ready1, done1},
                3'b110);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
